// File: rtl/alu_mem_arbiter.sv
// Round-robin arbiter that lets two requesters share one ALU/memory unit,
// with a single transaction in flight and a bounded wait for the unit.
module alu_mem_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [35:0] cmd0,
  input  logic [35:0] cmd1,
  output logic [1:0]  gnt,
  output logic [1:0]  rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  output logic        u_start,
  output logic [1:0]  u_op,
  output logic [1:0]  u_mem_op,
  output logic [7:0]  u_addr,
  output logic [7:0]  u_in_a,
  output logic [7:0]  u_in_b,
  output logic [7:0]  u_wdata,
  input  logic [15:0] u_result,
  input  logic        u_error,
  input  logic        u_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic        ptr_reg, ptr_next;
  logic        owner_reg, owner_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [1:0]  gnt_reg, gnt_next;
  logic [1:0]  rsp_valid_reg, rsp_valid_next;
  logic [15:0] rsp_data_reg, rsp_data_next;
  logic        rsp_err_reg, rsp_err_next;
  logic        rsp_timeout_reg, rsp_timeout_next;
  logic        busy_reg, busy_next;
  logic        u_start_reg, u_start_next;
  logic [1:0]  u_op_reg, u_op_next;
  logic [1:0]  u_mem_op_reg, u_mem_op_next;
  logic [7:0]  u_addr_reg, u_addr_next;
  logic [7:0]  u_in_a_reg, u_in_a_next;
  logic [7:0]  u_in_b_reg, u_in_b_next;
  logic [7:0]  u_wdata_reg, u_wdata_next;
  logic [35:0] cmd_sel;
  logic [8:0]  cnt_inc;

  assign cnt_inc = {1'b0, cnt_reg} + 9'd1;

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    owner_next       = owner_reg;
    cnt_next         = cnt_reg;
    gnt_next         = 2'b00;
    rsp_valid_next   = 2'b00;
    rsp_data_next    = rsp_data_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    busy_next        = busy_reg;
    u_start_next     = 1'b0;
    u_op_next        = u_op_reg;
    u_mem_op_next    = u_mem_op_reg;
    u_addr_next      = u_addr_reg;
    u_in_a_next      = u_in_a_reg;
    u_in_b_next      = u_in_b_reg;
    u_wdata_next     = u_wdata_reg;
    cmd_sel          = cmd0;

    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          // Contention resolved by the pointer; a lone requester always wins.
          owner_next    = (req == 2'b11) ? ptr_reg : req[1];
          cmd_sel       = owner_next ? cmd1 : cmd0;
          u_op_next     = cmd_sel[35:34];
          u_mem_op_next = cmd_sel[33:32];
          u_addr_next   = cmd_sel[31:24];
          u_in_a_next   = cmd_sel[23:16];
          u_in_b_next   = cmd_sel[15:8];
          u_wdata_next  = cmd_sel[7:0];
          gnt_next      = owner_next ? 2'b10 : 2'b01;
          u_start_next  = 1'b1;
          busy_next     = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = 8'd0;
        state_next = WAIT;
      end
      WAIT: begin
        if (u_done) begin
          // Writes carry no data back, so whatever the unit returns is masked.
          if (u_mem_op_reg == 2'b01) begin
            rsp_data_next = 16'h0000;
            rsp_err_next  = 1'b0;
          end else begin
            rsp_data_next = u_result;
            rsp_err_next  = u_error;
          end
          rsp_timeout_next = 1'b0;
          rsp_valid_next   = owner_reg ? 2'b10 : 2'b01;
          state_next       = RESP;
        end else begin
          cnt_next = cnt_inc[7:0];
          if (cnt_inc == 9'(TIMEOUT)) begin
            rsp_data_next    = 16'hFFFF;
            rsp_err_next     = 1'b1;
            rsp_timeout_next = 1'b1;
            rsp_valid_next   = owner_reg ? 2'b10 : 2'b01;
            state_next       = RESP;
          end
        end
      end
      RESP: begin
        ptr_next   = ~owner_reg;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= 1'b0;
      owner_reg       <= 1'b0;
      cnt_reg         <= 8'd0;
      gnt_reg         <= 2'b00;
      rsp_valid_reg   <= 2'b00;
      rsp_data_reg    <= 16'h0000;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      busy_reg        <= 1'b0;
      u_start_reg     <= 1'b0;
      u_op_reg        <= 2'b00;
      u_mem_op_reg    <= 2'b00;
      u_addr_reg      <= 8'd0;
      u_in_a_reg      <= 8'd0;
      u_in_b_reg      <= 8'd0;
      u_wdata_reg     <= 8'd0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      owner_reg       <= owner_next;
      cnt_reg         <= cnt_next;
      gnt_reg         <= gnt_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_data_reg    <= rsp_data_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
      busy_reg        <= busy_next;
      u_start_reg     <= u_start_next;
      u_op_reg        <= u_op_next;
      u_mem_op_reg    <= u_mem_op_next;
      u_addr_reg      <= u_addr_next;
      u_in_a_reg      <= u_in_a_next;
      u_in_b_reg      <= u_in_b_next;
      u_wdata_reg     <= u_wdata_next;
    end
  end

  assign gnt         = gnt_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_data    = rsp_data_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign busy        = busy_reg;
  assign u_start     = u_start_reg;
  assign u_op        = u_op_reg;
  assign u_mem_op    = u_mem_op_reg;
  assign u_addr      = u_addr_reg;
  assign u_in_a      = u_in_a_reg;
  assign u_in_b      = u_in_b_reg;
  assign u_wdata     = u_wdata_reg;

endmodule

// File: tb/tb_alu_mem_arbiter.sv
// Directed bench for alu_mem_arbiter with a one-cycle ALU/memory unit model
// that can be told to never answer.
module tb_alu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [35:0] cmd0 = '0;
  logic [35:0] cmd1 = '0;
  logic [1:0]  gnt, rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err, rsp_timeout, busy, u_start;
  logic [1:0]  u_op, u_mem_op;
  logic [7:0]  u_addr, u_in_a, u_in_b, u_wdata;
  logic [15:0] u_result = '0;
  logic        u_error = 1'b0;
  logic        u_done = 1'b0;
  logic        hang = 1'b0;
  logic [7:0]  mem [0:255];

  int total = 0;
  int bad = 0;

  alu_mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd0(cmd0), .cmd1(cmd1),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .u_start(u_start), .u_op(u_op), .u_mem_op(u_mem_op), .u_addr(u_addr),
    .u_in_a(u_in_a), .u_in_b(u_in_b), .u_wdata(u_wdata),
    .u_result(u_result), .u_error(u_error), .u_done(u_done)
  );

  always #5 clk = ~clk;

  // Unit model: answers on the cycle after u_start unless hang is set.
  always @(posedge clk) begin
    u_done <= 1'b0;
    if (u_start && !hang) begin
      u_done  <= 1'b1;
      u_error <= 1'b0;
      case (u_mem_op)
        2'b01: begin
          mem[u_addr] <= u_wdata;
          u_result    <= 16'hBEEF;
          u_error     <= 1'b1;
        end
        2'b10: u_result <= {8'h00, mem[u_addr]};
        default: begin
          case (u_op)
            2'b00: u_result <= {8'h00, u_in_a} + {8'h00, u_in_b};
            2'b01: u_result <= {8'h00, u_in_a} - {8'h00, u_in_b};
            2'b10: u_result <= {8'h00, u_in_a} * {8'h00, u_in_b};
            default: begin
              if (u_in_b == 8'd0) begin
                u_result <= 16'hFFFF;
                u_error  <= 1'b1;
              end else begin
                u_result <= {8'h00, u_in_a / u_in_b};
              end
            end
          endcase
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] mk(input logic [1:0] op, input logic [1:0] mop,
                                     input logic [7:0] addr, input logic [7:0] a,
                                     input logic [7:0] b, input logic [7:0] wd);
    return {op, mop, addr, a, b, wd};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one transaction from an IDLE cycle and returns in the following IDLE cycle.
  task automatic txn(input string tag, input logic [1:0] r, input logic drop,
                     input logic own, input int exp_lat, input logic [15:0] exp_data,
                     input logic exp_err, input logic exp_to, input logic [7:0] exp_a);
    int k;
    req = r;
    step();
    chk({tag, ".gnt"}, {30'd0, gnt}, own ? 32'd2 : 32'd1);
    chk({tag, ".start"}, {31'd0, u_start}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    if (drop) req = 2'b00;
    k = 0;
    while (rsp_valid == 2'b00 && k < 20) begin
      step();
      k++;
      if (k == 1) chk({tag, ".start_pulse"}, {30'd0, gnt, u_start}, 32'd0);
    end
    chk({tag, ".lat"}, k, exp_lat);
    chk({tag, ".rv"}, {30'd0, rsp_valid}, own ? 32'd2 : 32'd1);
    chk({tag, ".data"}, {16'd0, rsp_data}, {16'd0, exp_data});
    chk({tag, ".flags"}, {30'd0, rsp_err, rsp_timeout}, {30'd0, exp_err, exp_to});
    chk({tag, ".in_a_hold"}, {24'd0, u_in_a}, {24'd0, exp_a});
    $display("txn %s owner=%0d data=%h err=%0d to=%0d lat=%0d", tag, own, rsp_data,
             rsp_err, rsp_timeout, k);
    step();
    chk({tag, ".idle"}, {29'd0, rsp_valid, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    step();
    step();
    chk("reset_outs", {gnt, rsp_valid, rsp_err, rsp_timeout, busy, u_start, 24'd0},
        32'd0);
    chk("reset_data", {rsp_data, u_addr, u_in_a}, 32'd0);
    rst = 1'b1;
    step();

    // Contention alternates starting from requester 0.
    cmd0 = mk(2'b00, 2'b00, 8'h00, 8'd1, 8'd2, 8'h00);
    cmd1 = mk(2'b01, 2'b00, 8'h00, 8'd100, 8'd1, 8'h00);
    txn("rr0", 2'b11, 1'b0, 1'b0, 2, 16'd3, 1'b0, 1'b0, 8'd1);
    txn("rr1", 2'b11, 1'b0, 1'b1, 2, 16'd99, 1'b0, 1'b0, 8'd100);
    txn("rr2", 2'b11, 1'b0, 1'b0, 2, 16'd3, 1'b0, 1'b0, 8'd1);
    txn("rr3", 2'b11, 1'b1, 1'b1, 2, 16'd99, 1'b0, 1'b0, 8'd100);

    cmd0 = mk(2'b00, 2'b00, 8'h00, 8'd20, 8'd22, 8'h00);
    txn("add", 2'b01, 1'b1, 1'b0, 2, 16'd42, 1'b0, 1'b0, 8'd20);

    cmd0 = mk(2'b10, 2'b00, 8'h00, 8'd12, 8'd13, 8'h00);
    txn("mul", 2'b01, 1'b1, 1'b0, 2, 16'h009C, 1'b0, 1'b0, 8'd12);

    cmd1 = mk(2'b00, 2'b01, 8'h10, 8'd0, 8'd0, 8'hA5);
    txn("wr", 2'b10, 1'b1, 1'b1, 2, 16'h0000, 1'b0, 1'b0, 8'd0);
    cmd1 = mk(2'b00, 2'b10, 8'h10, 8'd0, 8'd0, 8'h00);
    txn("rd", 2'b10, 1'b1, 1'b1, 2, 16'h00A5, 1'b0, 1'b0, 8'd0);

    cmd0 = mk(2'b11, 2'b00, 8'h00, 8'd5, 8'd0, 8'h00);
    txn("div0", 2'b01, 1'b1, 1'b0, 2, 16'hFFFF, 1'b1, 1'b0, 8'd5);

    cmd1 = mk(2'b00, 2'b11, 8'h22, 8'd3, 8'd4, 8'h00);
    txn("mop11", 2'b10, 1'b1, 1'b1, 2, 16'd7, 1'b0, 1'b0, 8'd3);
    chk("mop11.pass", {30'd0, u_mem_op}, 32'd3);

    hang = 1'b1;
    cmd0 = mk(2'b00, 2'b00, 8'h33, 8'd9, 8'd9, 8'h00);
    txn("tmo", 2'b01, 1'b1, 1'b0, 9, 16'hFFFF, 1'b1, 1'b1, 8'd9);

    // Reset while the unit is stalled in WAIT.
    cmd0 = mk(2'b00, 2'b00, 8'h44, 8'd7, 8'd7, 8'h00);
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("arst_outs", {gnt, rsp_valid, rsp_err, rsp_timeout, busy, u_start, u_op, u_mem_op,
                      u_wdata, 8'd0}, 32'd0);
    chk("arst_data", {rsp_data, u_addr, u_in_a}, 32'd0);
    chk("arst_inb", {24'd0, u_in_b}, 32'd0);
    step();
    hang = 1'b0;
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid != 2'b00 || busy) seen++;
    end
    chk("arst_no_rsp", seen, 0);

    cmd1 = mk(2'b01, 2'b00, 8'h00, 8'd50, 8'd8, 8'h00);
    txn("post_rst", 2'b10, 1'b1, 1'b1, 2, 16'd42, 1'b0, 1'b0, 8'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mem_arbiter.md
ALU_MEM_ARBITER -- requirements
Module: alu_mem_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, giving the maximum WAIT cycles before abort (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 2 bits: req[i] is the request from requester i.
REQ-005 The block SHALL have ports cmd0 and cmd1, input, 36 bits each, packed {op[35:34], mem_op[33:32], addr[31:24], a[23:16], b[15:8], wdata[7:0]}.
REQ-006 The block SHALL have port gnt, output, 2 bits: one-cycle accept pulse per requester.
REQ-007 The block SHALL have port rsp_valid, output, 2 bits: one-cycle response pulse per requester.
REQ-008 The block SHALL have port rsp_data, output, 16 bits: response data, valid while any rsp_valid bit is high.
REQ-009 The block SHALL have ports rsp_err and rsp_timeout, output, 1 bit each: error and timeout flags, qualified by rsp_valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-011 The block SHALL have ports u_start (1), u_op (2), u_mem_op (2), u_addr (8), u_in_a (8), u_in_b (8) and u_wdata (8), output, driving the shared ALU/memory unit.
REQ-012 The block SHALL have ports u_result (16), u_error (1) and u_done (1), input, returned from the shared unit.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP, with exactly one transaction in flight.
REQ-015 In IDLE with req != 0, the block SHALL select the owner round-robin, latch that owner's cmd into u_* registers, pulse gnt[owner] for one cycle, and enter ISSUE.
- Round-robin: requester 0 wins when the pointer is 0, requester 1 wins when it is 1.
- A lone requester always wins.
REQ-016 The pointer SHALL update in RESP to point at the non-owner, so simultaneous requests alternate 0,1,0,1.
REQ-017 In ISSUE, u_start SHALL be 1 for exactly one cycle, the wait counter SHALL clear, and the next state SHALL be WAIT.
REQ-018 u_op, u_mem_op, u_addr, u_in_a, u_in_b and u_wdata SHALL hold stable from ISSUE through RESP.
REQ-019 In WAIT with u_done=1, the block SHALL capture u_result into rsp_data and u_error into rsp_err, set rsp_timeout=0, and enter RESP.
REQ-020 For a memory write (mem_op=01), rsp_data SHALL be forced to 0 and rsp_err to 0.
REQ-021 In WAIT with u_done=0, the counter SHALL increment; on reaching TIMEOUT, rsp_data SHALL be 16'hFFFF, rsp_err=1, rsp_timeout=1, and the next state SHALL be RESP.
REQ-022 In RESP, rsp_valid[owner] SHALL be 1 for one cycle, then the FSM SHALL return to IDLE; rsp_data/rsp_err/rsp_timeout SHALL hold until the next capture.
REQ-023 Latency: for a req sampled in IDLE at edge N, gnt and u_start SHALL be high in cycle N+1 and rsp_valid in cycle N+3; back-to-back throughput SHALL be one transaction per 4 cycles.
REQ-024 Requesters SHALL hold req and cmd until gnt; req dropped before gnt SHALL be ignored with no response.
REQ-025 req asserted while busy SHALL wait, and req held after gnt SHALL be treated as a new request on the next IDLE.
REQ-026 mem_op=11 SHALL be passed through to the unit unchanged (ALU op) and handled as a non-write.

Reset
REQ-027 With rst=0, asynchronously: state=IDLE, pointer=0, counter=0, and gnt, rsp_valid, rsp_data, rsp_err, rsp_timeout, busy and all u_* outputs = 0.
REQ-028 Reset mid-transaction SHALL drop the transaction with no rsp_valid after release.
REQ-029 The first request after reset release SHALL be arbitrated normally in IDLE.

Verification
REQ-030 req=01, cmd0 {op=00, mem_op=00, a=8'd20, b=8'd22} -> gnt=01 in N+1, u_start one cycle, rsp_valid=01 in N+3, rsp_data=16'd42, rsp_err=0.
REQ-031 req=11 held for 4 transactions -> grant order 0,1,0,1, each rsp_valid to the matching bit, 4 cycles apart.
REQ-032 Requester 1 writes mem_op=01 addr=8'h10 wdata=8'hA5, then requester 1 reads mem_op=10 addr=8'h10 -> write rsp_data=0, read rsp_data=16'h00A5.
REQ-033 op=11, b=0 (unit returns FFFF, error=1) -> rsp_data=16'hFFFF, rsp_err=1, rsp_timeout=0.
REQ-034 Unit model holding u_done=0, TIMEOUT=8 -> rsp_valid exactly 8 WAIT cycles after ISSUE, rsp_data=16'hFFFF, rsp_err=1, rsp_timeout=1.
REQ-035 rst=0 asserted during WAIT -> all outputs 0 immediately, no rsp_valid after release, next req=10 granted to requester 1 normally.
